ball_engine: RTL and testbench

Per-frame ball motion and collision engine for the breakout game. Sits between the paddle/brick state and the score counter and VGA display. Each frame it advances the ball and resolves wall, brick and paddle collisions. It produces the ball coordinates consumed by `display` and the one-cycle `hit` strobe consumed by `score`, which replaces the constant `hit = 0` tie-off.

---
 rtl/ball_engine.sv | 179 +++++++++++++++++
 tb/tb_ball_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Breakout ball engine: serves the ball from the paddle, advances it once per frame
// and resolves wall, brick, paddle and bottom-edge events through a CALC/CHECK pair.
module ball_engine #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 8,
    parameter int SPEED     = 2,
    parameter int PADDLE_W  = 64,
    parameter int PADDLE_Y  = 296,
    parameter int BRICK_Y   = 40,
    parameter int BRICK_H   = 16,
    parameter int BRICK_W   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic       pause,
    input  logic [9:0] paddle_x,
    input  logic [9:0] brick_alive,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       serving,
    output logic       hit,
    output logic [3:0] brick_idx,
    output logic       lost
);
    typedef enum logic [1:0] {SERVE, MOVE, CALC, CHECK} state_t;

    localparam int BRICK_SHIFT = $clog2(BRICK_W);
    localparam logic signed [10:0] SPD       = 11'(SPEED);
    localparam logic signed [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] BS_S      = 11'(BALL_SIZE);
    localparam logic signed [10:0] HALF_S    = 11'(BALL_SIZE / 2);
    localparam logic signed [10:0] H_S       = 11'(SCREEN_H);
    localparam logic signed [10:0] PY_S      = 11'(PADDLE_Y);
    localparam logic signed [10:0] PW_S      = 11'(PADDLE_W);
    localparam logic signed [10:0] BRICK_TOP = 11'(BRICK_Y);
    localparam logic signed [10:0] BRICK_BOT = 11'(BRICK_Y + BRICK_H);
    localparam logic [10:0]        N_BRICKS  = 11'(SCREEN_W / BRICK_W);
    localparam logic [9:0]         RESET_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         SERVE_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]         SERVE_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
    logic               dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic               launch_prev_q, launch_prev_d;
    logic               serving_q, serving_d;
    logic               hit_q, hit_d, lost_q, lost_d;
    logic [3:0]         idx_q, idx_d;

    logic signed [10:0] xs, ys, dx_s, dy_s, cx, px_s;
    logic [10:0]        col;
    logic [15:0]        alive_pad;
    logic [9:0]         serve_x;
    logic               brick_live, paddle_catch;

    assign xs        = $signed({1'b0, x_q});
    assign ys        = $signed({1'b0, y_q});
    assign px_s      = $signed({1'b0, paddle_x});
    assign dx_s      = dx_neg_q ? -SPD : SPD;
    assign dy_s      = dy_neg_q ? -SPD : SPD;
    assign serve_x   = paddle_x + SERVE_OFS;
    // Brick column from the ball centre; columns past the last brick never count as alive.
    assign cx        = nx_q + HALF_S;
    assign col       = $unsigned(cx) >> BRICK_SHIFT;
    assign alive_pad = {6'b0, brick_alive};
    assign brick_live = (col < N_BRICKS) && alive_pad[col[3:0]];
    // Difference form keeps the paddle range check clear of 11-bit overflow.
    assign paddle_catch = !dy_neg_q && (ys + BS_S <= PY_S) && (ny_q + BS_S >= PY_S)
                          && (cx >= px_s) && (cx - px_s < PW_S);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        dx_neg_d      = dx_neg_q;
        dy_neg_d      = dy_neg_q;
        serving_d     = serving_q;
        hit_d         = 1'b0;
        lost_d        = 1'b0;
        idx_d         = idx_q;
        launch_prev_d = launch;
        case (state_q)
            SERVE: begin
                x_d = serve_x;
                y_d = SERVE_Y;
                if (launch && !launch_prev_q && !pause) begin
                    state_d   = MOVE;
                    dx_neg_d  = 1'b0;
                    dy_neg_d  = 1'b1;
                    serving_d = 1'b0;
                end
            end
            MOVE: begin
                if (frame_tick && !pause) state_d = CALC;
            end
            CALC: begin
                nx_d = xs + dx_s;
                ny_d = ys + dy_s;
                if (dx_neg_q && xs < SPD) begin
                    nx_d     = '0;
                    dx_neg_d = 1'b0;
                end else if (!dx_neg_q && xs + SPD > X_MAX) begin
                    nx_d     = X_MAX;
                    dx_neg_d = 1'b1;
                end
                if (dy_neg_q && ys < SPD) begin
                    ny_d     = '0;
                    dy_neg_d = 1'b0;
                end
                state_d = CHECK;
            end
            CHECK: begin
                state_d = MOVE;
                x_d     = nx_q[9:0];
                y_d     = ny_q[9:0];
                if (ny_q + BS_S >= H_S) begin
                    lost_d    = 1'b1;
                    state_d   = SERVE;
                    serving_d = 1'b1;
                    x_d       = serve_x;
                    y_d       = SERVE_Y;
                    dx_neg_d  = 1'b0;
                    dy_neg_d  = 1'b1;
                end else if (ny_q < BRICK_BOT && ny_q + BS_S > BRICK_TOP && brick_live) begin
                    hit_d    = 1'b1;
                    idx_d    = col[3:0];
                    dy_neg_d = !dy_neg_q;
                end else if (paddle_catch) begin
                    y_d      = SERVE_Y;
                    dy_neg_d = 1'b1;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SERVE;
            x_q           <= RESET_X;
            y_q           <= SERVE_Y;
            nx_q          <= '0;
            ny_q          <= '0;
            dx_neg_q      <= 1'b0;
            dy_neg_q      <= 1'b1;
            launch_prev_q <= 1'b1;
            serving_q     <= 1'b1;
            hit_q         <= 1'b0;
            lost_q        <= 1'b0;
            idx_q         <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
            dx_neg_q      <= dx_neg_d;
            dy_neg_q      <= dy_neg_d;
            launch_prev_q <= launch_prev_d;
            serving_q     <= serving_d;
            hit_q         <= hit_d;
            lost_q        <= lost_d;
            idx_q         <= idx_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign serving   = serving_q;
    assign hit       = hit_q;
    assign lost      = lost_q;
    assign brick_idx = idx_q;
endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed serve/pause/reset/launch scenarios, then random play
// checked every cycle against a frame-level reference model.
module tb_ball_engine;
    localparam int W = 640, H = 480, BS = 8, SP = 2, PW = 64, PY = 296;
    localparam int BY = 40, BH = 16, BW = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick, launch, pause;
    logic [9:0] paddle_x, brick_alive;
    logic [9:0] ball_x, ball_y;
    logic       serving, hit, lost;
    logic [3:0] brick_idx;

    always #5 clk = ~clk;

    ball_engine dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch), .pause(pause),
        .paddle_x(paddle_x), .brick_alive(brick_alive), .ball_x(ball_x), .ball_y(ball_y),
        .serving(serving), .hit(hit), .brick_idx(brick_idx), .lost(lost)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: ball position/direction as plain integers, plus a countdown
    // of cycles until the frame result lands (2 = just accepted, 1 = result next edge).
    int m_x, m_y, m_dx, m_dy, m_busy, m_idx;
    bit m_serving, m_hit, m_lost, m_lprev;
    int n_hits = 0, n_lost = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_x = (W - BS) / 2; m_y = PY - BS; m_dx = SP; m_dy = -SP;
        m_serving = 1; m_busy = 0; m_hit = 0; m_lost = 0; m_idx = 0; m_lprev = 1;
    endfunction

    function automatic void m_frame(output bit h, output bit l);
        int nx, ny, c, idx;
        h = 0; l = 0;
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        if (m_dx < 0 && m_x < SP) begin nx = 0; m_dx = SP; end
        else if (m_dx > 0 && m_x + SP > W - BS) begin nx = W - BS; m_dx = -SP; end
        if (m_dy < 0 && m_y < SP) begin ny = 0; m_dy = SP; end
        c = nx + BS / 2;
        idx = c / BW;
        if (ny + BS >= H) begin
            l = 1; m_serving = 1;
            m_x = int'(paddle_x) + PW / 2 - BS / 2; m_y = PY - BS; m_dx = SP; m_dy = -SP;
        end else if (ny < BY + BH && ny + BS > BY && idx < 10 && brick_alive[idx]) begin
            h = 1; m_idx = idx; m_dy = -m_dy; m_x = nx; m_y = ny;
        end else if (m_dy > 0 && m_y + BS <= PY && ny + BS >= PY
                     && c >= int'(paddle_x) && c < int'(paddle_x) + PW) begin
            m_x = nx; m_y = PY - BS; m_dy = -SP;
        end else begin
            m_x = nx; m_y = ny;
        end
    endfunction

    function automatic void m_clock();
        bit h, l;
        h = 0; l = 0;
        if (m_serving) begin
            m_x = int'(paddle_x) + PW / 2 - BS / 2;
            m_y = PY - BS;
            if (launch && !m_lprev && !pause) begin
                m_serving = 0; m_dx = SP; m_dy = -SP;
            end
        end else if (m_busy == 2) begin
            m_busy = 1;
        end else if (m_busy == 1) begin
            m_busy = 0;
            m_frame(h, l);
        end else if (frame_tick && !pause) begin
            m_busy = 2;
        end
        m_hit = h; m_lost = l; m_lprev = launch;
        if (h) n_hits++;
        if (l) n_lost++;
    endfunction

    task automatic compare_model();
        chk("ball_x", ball_x, m_x);
        chk("ball_y", ball_y, m_y);
        chk("serving", serving, m_serving);
        chk("hit", hit, m_hit);
        chk("lost", lost, m_lost);
        chk("brick_idx", brick_idx, m_idx);
    endtask

    // Called at a negedge: drive inputs, advance one clock, update model, compare.
    task automatic cycle(input bit tk, input bit ln, input bit ps);
        frame_tick = tk; launch = ln; pause = ps;
        @(posedge clk);
        if (rst) m_clock(); else m_reset();
        @(negedge clk);
        compare_model();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, ball_x, 316);
        chk({tag, "_y"}, ball_y, 288);
        chk({tag, "_serving"}, serving, 1);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_lost"}, lost, 0);
        chk({tag, "_idx"}, brick_idx, 0);
    endtask

    bit ln_lvl, ps_lvl, track, tk;
    int p, rst_hold;

    initial begin
        frame_tick = 0; launch = 0; pause = 0; paddle_x = 10'd100; brick_alive = 10'h3FF;
        #1 rst = 1'b0;
        #2 chk_reset_vals("reset");
        m_reset();
        @(negedge clk);
        rst = 1'b1;

        // Serve follows the paddle, launch edge releases, first frame lands 3 cycles on
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("serve_x", ball_x, 128);
        chk("serve_y", ball_y, 288);
        chk("serve_flag", serving, 1);
        cycle(0, 1, 0);
        chk("launch_serving", serving, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        chk("pre_frame_x", ball_x, 128);
        chk("pre_frame_y", ball_y, 288);
        cycle(0, 0, 0);
        chk("frame1_x", ball_x, 130);
        chk("frame1_y", ball_y, 286);

        // Ticks while paused are dropped
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1);
            cycle(0, 0, 1);
            cycle(0, 0, 1);
        end
        cycle(0, 0, 0);
        chk("pause_x", ball_x, 130);
        chk("pause_y", ball_y, 286);

        // Reset asserted while a frame is in flight
        cycle(1, 0, 0);
        rst = 1'b0;
        #1 chk_reset_vals("midflight");
        m_reset();
        cycle(0, 0, 0);
        cycle(0, 1, 0);

        // Launch held through reset release must not serve
        rst = 1'b1;
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        chk("held_launch", serving, 1);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("relaunch", serving, 0);

        // Random play
        ln_lvl = 1; ps_lvl = 0; track = 1; rst_hold = 0;
        for (int i = 0; i < 12000; i++) begin
            tk = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) ln_lvl = ~ln_lvl;
            if (!ps_lvl && $urandom_range(0, 149) == 0) ps_lvl = 1;
            else if (ps_lvl && $urandom_range(0, 19) == 0) ps_lvl = 0;
            if ($urandom_range(0, 299) == 0) track = ($urandom_range(0, 2) != 0);
            if (track) begin
                p = m_x - 28 + int'($urandom_range(0, 40)) - 20;
                if (p < 0) p = 0;
                if (p > W - PW) p = W - PW;
                paddle_x = 10'(p);
            end else if ($urandom_range(0, 99) == 0) begin
                paddle_x = 10'($urandom_range(0, W - PW));
            end
            if (m_hit) brick_alive[m_idx] = 1'b0;
            if (brick_alive == 10'h000 || $urandom_range(0, 1999) == 0)
                brick_alive = 10'($urandom_range(0, 1023));
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end else if ($urandom_range(0, 3999) == 0) begin
                rst = 1'b0;
                rst_hold = int'($urandom_range(1, 3));
            end
            cycle(tk, ln_lvl, ps_lvl);
        end

        $display("random play: hits=%0d lost=%0d", n_hits, n_lost);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
